// File: rtl/seq_divider_if.sv
// Divide request/response bundle between the ALU (master) and the divide engine (slave).
interface seq_divider_if #(
  parameter int WIDTH = 32
) ();
  logic                 signed_div;
  logic [WIDTH-1:0]     opdata1;
  logic [WIDTH-1:0]     opdata2;
  logic                 start;
  logic                 annul;
  logic [2*WIDTH-1:0]   result;
  logic                 ready;
  logic                 busy;

  modport master (
    output signed_div, opdata1, opdata2, start, annul,
    input  result, ready, busy
  );

  modport slave (
    input  signed_div, opdata1, opdata2, start, annul,
    output result, ready, busy
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for DIV/DIVU: result = {remainder, quotient}.
// Ready rises WIDTH+1 edges after start is sampled (1 edge for divide-by-zero); annul aborts.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  seq_divider_if.slave dif
);
  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WIDTH);

  localparam logic [1:0] S_FREE = 2'd0;
  localparam logic [1:0] S_DZ   = 2'd1;
  localparam logic [1:0] S_ON   = 2'd2;
  localparam logic [1:0] S_END  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               signed_q, signed_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               a_neg;
  logic               b_neg;

  // dvd_q doubles as the quotient shift register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  assign trial    = {rem_q, dvd_q[WIDTH-1]};
  assign diff     = trial - {1'b0, dvs_q};
  assign quot_fix = (signed_q && (sa_q ^ sb_q)) ? -dvd_q : dvd_q;
  assign rem_fix  = (signed_q && sa_q) ? -rem_q : rem_q;
  assign a_neg    = dif.signed_div & dif.opdata1[WIDTH-1];
  assign b_neg    = dif.signed_div & dif.opdata2[WIDTH-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    signed_d = signed_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    ready_d  = ready_q;
    case (state_q)
      S_FREE: begin
        if (dif.start && !dif.annul) begin
          if (dif.opdata2 == '0) begin
            state_d = S_DZ;
            dvd_d   = dif.opdata1;
          end else begin
            state_d  = S_ON;
            signed_d = dif.signed_div;
            sa_d     = a_neg;
            sb_d     = b_neg;
            dvd_d    = a_neg ? -dif.opdata1 : dif.opdata1;
            dvs_d    = b_neg ? -dif.opdata2 : dif.opdata2;
            cnt_d    = '0;
            rem_d    = '0;
          end
        end
      end
      S_ON: begin
        if (dif.annul) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (cnt_q == CNT_DONE) begin
          state_d  = S_END;
          ready_d  = 1'b1;
          result_d = {rem_fix, quot_fix};
        end else begin
          // A borrow out of the trial subtraction means the divisor did not fit.
          if (diff[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
          end else begin
            rem_d = diff[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
          end
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DZ: begin
        if (dif.annul) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          state_d  = S_END;
          ready_d  = 1'b1;
          result_d = {dvd_q, {WIDTH{1'b1}}};
        end
      end
      default: begin
        if (dif.annul || !dif.start) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      signed_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      signed_q <= signed_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign dif.result = result_q;
  assign dif.ready  = ready_q;
  assign dif.busy   = (state_q == S_ON) || (state_q == S_DZ);
endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed checks of seq_divider against an arithmetic reference model.
module tb_seq_divider;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_divider_if #(.WIDTH(32)) dif ();

  seq_divider #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {remainder, quotient} from plain integer arithmetic.
  function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!sg) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    return {r, q};
  endfunction

  // Runs one operation with start held; returns latency in edges after the sampling edge (-1 on timeout).
  task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [63:0] res,
                        output logic busy_e0, output logic rdy_rel);
    dif.signed_div = sg;
    dif.opdata1    = a;
    dif.opdata2    = b;
    dif.annul      = 1'b0;
    dif.start      = 1'b1;
    @(posedge clk); #1;
    busy_e0        = dif.busy;
    dif.signed_div = 1'($urandom);
    dif.opdata1    = $urandom;
    dif.opdata2    = $urandom;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (dif.ready) begin
        lat = i;
        break;
      end
    end
    res = dif.result;
    dif.start = 1'b0;
    @(posedge clk); #1;
    rdy_rel = dif.ready;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    dif.start = 1'b0;
    dif.annul = 1'b0;
    dif.signed_div = 1'b0;
    dif.opdata1 = '0;
    dif.opdata2 = '0;
    #12;
    checks++; if (dif.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", dif.ready); end
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", dif.busy); end
    checks++; if (dif.result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", dif.result); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_divu_basic;
    int lat; logic [63:0] res; logic be; logic rr;
    run_op(1'b0, 32'd100, 32'd7, lat, res, be, rr);
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_latency: got %0d expected 33", lat); end
    checks++; if (res !== 64'h00000002_0000000E) begin errors++; $display("FAIL divu_100_7: got %h expected 000000020000000e", res); end
    checks++; if (be !== 1'b1) begin errors++; $display("FAIL divu_busy: got %b expected 1", be); end
    checks++; if (rr !== 1'b0) begin errors++; $display("FAIL divu_release: got %b expected 0", rr); end
  endtask

  task automatic test_signed;
    int lat; logic [63:0] res; logic be; logic rr;
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, res, be, rr);
    checks++; if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin errors++; $display("FAIL div_m7_2: got %h expected fffffffffffffffd", res); end
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat, res, be, rr);
    checks++; if (res !== {32'h1, 32'hFFFF_FFFD}) begin errors++; $display("FAIL div_7_m2: got %h expected 00000001fffffffd", res); end
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, be, rr);
    checks++; if (res !== {32'h0, 32'h8000_0000}) begin errors++; $display("FAIL div_overflow: got %h expected 0000000080000000", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_overflow_latency: got %0d expected 33", lat); end
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, be, rr);
    checks++; if (res !== {32'h8000_0000, 32'h0}) begin errors++; $display("FAIL divu_big: got %h expected 8000000000000000", res); end
  endtask

  task automatic test_div_zero;
    int lat; logic [63:0] res; logic be; logic rr;
    run_op(1'b0, 32'h1234, 32'd0, lat, res, be, rr);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency: got %0d expected 1", lat); end
    checks++; if (res !== {32'h1234, 32'hFFFF_FFFF}) begin errors++; $display("FAIL dz_result: got %h expected 00001234ffffffff", res); end
    checks++; if (be !== 1'b1) begin errors++; $display("FAIL dz_busy: got %b expected 1", be); end
  endtask

  task automatic test_annul;
    int lat; logic [63:0] res; logic be; logic rr;
    // annul while in ON
    dif.signed_div = 1'b0; dif.opdata1 = 32'd100; dif.opdata2 = 32'd7; dif.start = 1'b1;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1 dif.annul = 1'b1;
    @(posedge clk); #1;
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL annul_on_busy: got %b expected 0", dif.busy); end
    checks++; if (dif.ready !== 1'b0) begin errors++; $display("FAIL annul_on_ready: got %b expected 0", dif.ready); end
    // annul beats start while in FREE
    @(posedge clk); #1;
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL annul_free_busy: got %b expected 0", dif.busy); end
    dif.annul = 1'b0; dif.start = 1'b0;
    @(posedge clk); #1;
    run_op(1'b0, 32'd9, 32'd3, lat, res, be, rr);
    checks++; if (res !== {32'd0, 32'd3}) begin errors++; $display("FAIL annul_next_result: got %h expected 0000000000000003", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL annul_next_latency: got %0d expected 33", lat); end
    // annul while in END, start still held
    dif.opdata1 = 32'd50; dif.opdata2 = 32'd0; dif.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dif.ready !== 1'b1) begin errors++; $display("FAIL end_hold_ready: got %b expected 1", dif.ready); end
    checks++; if (dif.result !== {32'd50, 32'hFFFF_FFFF}) begin errors++; $display("FAIL end_hold_result: got %h expected 00000032ffffffff", dif.result); end
    dif.annul = 1'b1;
    @(posedge clk); #1;
    checks++; if (dif.ready !== 1'b0) begin errors++; $display("FAIL annul_end_ready: got %b expected 0", dif.ready); end
    checks++; if (dif.result !== 64'd0) begin errors++; $display("FAIL annul_end_result: got %h expected 0", dif.result); end
    dif.annul = 1'b0; dif.start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    int lat; logic [63:0] res; logic be; logic rr;
    dif.signed_div = 1'b1; dif.opdata1 = 32'd1000; dif.opdata2 = 32'd3; dif.start = 1'b1;
    repeat (6) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL arst_on_busy: got %b expected 0", dif.busy); end
    checks++; if (dif.ready !== 1'b0) begin errors++; $display("FAIL arst_on_ready: got %b expected 0", dif.ready); end
    dif.start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    // reset while a result is being presented
    dif.opdata1 = 32'h77; dif.opdata2 = 32'd0; dif.start = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++; if (dif.result !== 64'd0) begin errors++; $display("FAIL arst_end_result: got %h expected 0", dif.result); end
    checks++; if (dif.ready !== 1'b0) begin errors++; $display("FAIL arst_end_ready: got %b expected 0", dif.ready); end
    dif.start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    run_op(1'b0, 32'd10, 32'd4, lat, res, be, rr);
    checks++; if (res !== {32'd2, 32'd2}) begin errors++; $display("FAIL arst_next_result: got %h expected 0000000200000002", res); end
  endtask

  task automatic test_back_to_back_random;
    int lat; logic [63:0] res; logic be; logic rr;
    logic sg; logic [31:0] a; logic [31:0] b; logic [63:0] exp_res; int exp_lat;
    for (int n = 0; n < 60; n++) begin
      sg = 1'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        4: a = 32'($urandom_range(0, 20));
        default: ;
      endcase
      exp_res = ref_div(sg, a, b);
      exp_lat = (b == 32'd0) ? 1 : 33;
      run_op(sg, a, b, lat, res, be, rr);
      checks++; if (res !== exp_res) begin errors++; $display("FAIL rand_result[%0d] sg=%b a=%h b=%h: got %h expected %h", n, sg, a, b, res, exp_res); end
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, exp_lat); end
      checks++; if (rr !== 1'b0) begin errors++; $display("FAIL rand_release[%0d]: got %b expected 0", n, rr); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_zero();
    test_annul();
    test_async_reset();
    test_back_to_back_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
